// File: rtl/edge_stream_ctrl.sv
// Frame-level controller for the luma-difference edge detector.
// Streams one W x H raster frame through a horizontal nibble-difference edge test,
// with valid/ready handshakes on both sides and per-frame edge counting.
module edge_stream_ctrl #(
    parameter int unsigned W          = 640,
    parameter int unsigned H          = 480,
    parameter int unsigned CNT_W      = 19,
    parameter logic [3:0]  DEF_THRESH = 4'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_thresh,
    input  logic             pix_valid,
    input  logic [23:0]      pix_in,
    output logic             pix_ready,
    output logic             out_valid,
    output logic [23:0]      pix_out,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] edge_count
);

    localparam int unsigned      COL_W    = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned      ROW_W    = (H > 1) ? $clog2(H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       thresh_q, thresh_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [3:0]       prev_q, prev_d;
    logic             out_valid_q, out_valid_d;
    logic [23:0]      pix_out_q, pix_out_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       accept;
    logic       is_edge;
    logic       last_pix;
    logic [3:0] nib;
    logic [3:0] diff;

    // A new pixel is taken only when the output register is free or being drained.
    assign pix_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept    = pix_valid && pix_ready;
    assign nib       = pix_in[23:20];
    // Absolute difference: larger minus smaller, so no 4-bit wrap.
    assign diff      = (nib >= prev_q) ? (nib - prev_q) : (prev_q - nib);
    // Column 0 has no left neighbour on this line, so it never reports an edge.
    assign is_edge   = (col_q != '0) && (diff >= thresh_q);
    assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);

    assign out_valid  = out_valid_q;
    assign pix_out    = pix_out_q;
    assign edge_count = count_q;
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign frame_done = (state_q == StDone);

    // Next-state logic: output handshake, pixel datapath, then frame sequencing.
    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        col_d       = col_q;
        row_d       = row_q;
        prev_d      = prev_q;
        out_valid_d = out_valid_q;
        pix_out_d   = pix_out_q;
        count_d     = count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            pix_out_d   = is_edge ? 24'hFFFFFF : 24'h000000;
            out_valid_d = 1'b1;
            prev_d      = nib;
            if (is_edge && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_we) begin
                    thresh_d = cfg_thresh;
                end
                if (start) begin
                    state_d = StRun;
                    count_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StRun: begin
                if (accept && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-frame discards the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            thresh_q    <= DEF_THRESH;
            col_q       <= '0;
            row_q       <= '0;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            pix_out_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            col_q       <= col_d;
            row_q       <= row_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            pix_out_q   <= pix_out_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_edge_stream_ctrl.sv
// Scoreboard bench for edge_stream_ctrl on a small 4x2 frame.
module tb_edge_stream_ctrl;

    localparam int unsigned W          = 4;
    localparam int unsigned H          = 2;
    localparam int unsigned N_PIX      = W * H;
    localparam int unsigned CNT_W      = 4;
    localparam logic [3:0]  DEF_THRESH = 4'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cfg_we;
    logic [3:0]       cfg_thresh;
    logic             pix_valid;
    logic [23:0]      pix_in;
    logic             pix_ready;
    logic             out_valid;
    logic [23:0]      pix_out;
    logic             out_ready;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] edge_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_q [$];
    logic [3:0]  stim [N_PIX];
    logic [3:0]  m_thresh;
    logic [3:0]  m_prev;
    int          m_col;
    int          m_count;

    always #5 clk = ~clk;

    edge_stream_ctrl #(
        .W         (W),
        .H         (H),
        .CNT_W     (CNT_W),
        .DEF_THRESH(DEF_THRESH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_thresh(cfg_thresh),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_ready (pix_ready),
        .out_valid (out_valid),
        .pix_out   (pix_out),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done),
        .edge_count(edge_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of one accepted pixel; pushes the expected result.
    task automatic model_accept(input logic [3:0] n);
        int  d;
        bit  e;
        d = int'(n) - int'(m_prev);
        if (d < 0) d = -d;
        e = (m_col != 0) && (d >= int'(m_thresh));
        exp_q.push_back(e ? 24'hFFFFFF : 24'h000000);
        if (e) m_count++;
        m_prev = n;
        m_col  = (m_col + 1) % W;
    endtask

    task automatic load_stim(input logic [31:0] nibs);
        for (int i = 0; i < N_PIX; i++) stim[i] = nibs[31-4*i -: 4];
    endtask

    task automatic do_start(input bit we, input logic [3:0] th);
        @(negedge clk);
        start      = 1'b1;
        cfg_we     = we;
        cfg_thresh = th;
        if (we) m_thresh = th;
        m_count = 0;
        m_col   = 0;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    // One full frame; out_ready low for cycles [stall_lo, stall_hi), cfg_we pulsed at cfg_cyc.
    task automatic run_frame(input logic [31:0] nibs, input bit we, input logic [3:0] th,
                             input int stall_lo, input int stall_hi, input int cfg_cyc,
                             input int exp_count);
        int          idx      = 0;
        int          cyc      = 0;
        int          last_pop = -1;
        int          done_cyc = -1;
        bit          held_ok  = 1'b0;
        logic [23:0] held     = '0;
        logic [31:0] rnd;
        load_stim(nibs);
        do_start(we, th);
        while (done_cyc < 0 && cyc < 100) begin
            cyc++;
            if (frame_done) begin
                done_cyc = cyc;
            end else begin
                out_ready  = !(cyc >= stall_lo && cyc < stall_hi);
                cfg_we     = (cyc == cfg_cyc);
                cfg_thresh = 4'hF;
                rnd        = $urandom();
                pix_valid  = (idx < N_PIX);
                if (idx < N_PIX) pix_in = {stim[idx], rnd[19:0]};
                else             pix_in = {4'h0, rnd[19:0]};
                #1;
                if (!out_ready && out_valid) begin
                    check_eq("stall_pix_ready", pix_ready, 0);
                    if (held_ok) check_eq("stall_pix_out_stable", pix_out, held);
                    held    = pix_out;
                    held_ok = 1'b1;
                end else begin
                    held_ok = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("spurious_output", exp_q.size(), 1);
                    else                   check_eq("pix_out", pix_out, exp_q.pop_front());
                    last_pop = cyc;
                end
                if (pix_valid && pix_ready) begin
                    model_accept(stim[idx]);
                    idx++;
                end
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        check_eq("frame_done_seen", done_cyc > 0, 1);
        check_eq("busy_in_done", busy, 0);
        check_eq("frame_done_after_last", done_cyc, last_pop + 1);
        check_eq("frame_cycles", done_cyc, N_PIX + 2 + (stall_hi - stall_lo));
        check_eq("pixels_accepted", idx, N_PIX);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        check_eq("edge_count_model", edge_count, m_count);
        check_eq("edge_count_hand", edge_count, exp_count);
        @(negedge clk);
        check_eq("frame_done_pulse_width", frame_done, 0);
        check_eq("edge_count_held", edge_count, exp_count);
    endtask

    // Frame interrupted by reset while pixel 3 is presented.
    task automatic run_reset(input logic [31:0] nibs, input logic [3:0] th);
        int idx = 0;
        int cyc = 0;
        load_stim(nibs);
        do_start(1'b1, th);
        while (cyc < 20) begin
            cyc++;
            out_ready = 1'b1;
            pix_valid = 1'b1;
            pix_in    = {stim[idx], 20'h0};
            if (idx == 3) begin
                check_eq("count_before_reset", edge_count, m_count);
                rst = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                pix_valid = 1'b0;
                check_eq("rst_mid_out_valid", out_valid, 0);
                check_eq("rst_mid_busy", busy, 0);
                check_eq("rst_mid_edge_count", edge_count, 0);
                check_eq("rst_mid_pix_out", pix_out, 0);
                check_eq("rst_mid_frame_done", frame_done, 0);
                exp_q.delete();
                m_thresh = DEF_THRESH;
                break;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_output", exp_q.size(), 1);
                else                   check_eq("pix_out_pre_rst", pix_out, exp_q.pop_front());
            end
            if (pix_valid && pix_ready) begin
                model_accept(stim[idx]);
                idx++;
            end
            @(negedge clk);
        end
        check_eq("reset_reached", idx, 3);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_we     = 1'b0;
        cfg_thresh = 4'h0;
        pix_valid  = 1'b0;
        pix_in     = '0;
        out_ready  = 1'b1;
        m_thresh   = DEF_THRESH;
        m_prev     = 4'h0;
        m_col      = 0;
        m_count    = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_pix_out", pix_out, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_frame_done", frame_done, 0);
        check_eq("reset_edge_count", edge_count, 0);
        check_eq("reset_pix_ready", pix_ready, 0);

        // Pixels offered while idle must be ignored.
        pix_valid = 1'b1;
        pix_in    = 24'hF00000;
        #1;
        check_eq("idle_pix_ready", pix_ready, 0);
        @(negedge clk);
        check_eq("idle_out_valid", out_valid, 0);
        pix_valid = 1'b0;

        // Default threshold; row 1 starts low after row 0 ends high (line-start suppression).
        run_frame(32'h077F_0000, 1'b0, 4'h0, 0, 0, 0, 2);
        // Back-pressure for three cycles mid-frame.
        run_frame(32'h3C19_90FE, 1'b0, 4'h0, 3, 6, 0, 5);
        // Threshold 2 written with start; a cfg write during RUN is ignored.
        run_frame(32'h5344_ABDD, 1'b1, 4'h2, 0, 0, 2, 2);
        // Threshold 8: descending and ascending differences, no 4-bit wrap.
        run_frame(32'hC41E_4CF2, 1'b1, 4'h8, 0, 0, 0, 4);
        // Reset mid-frame, then a clean frame that only matches with the default threshold.
        run_reset(32'h092F_0000, 4'h3);
        run_frame(32'h055D_26EE, 1'b0, 4'h0, 0, 0, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_stream_ctrl.md
Name: edge_stream_ctrl

Overview:
Frame-level controller for the luma-difference edge detector datapath. Sequences one W×H raster frame of 24-bit RGB pixels through a horizontal nibble-difference edge test with a programmable threshold. Uses valid/ready handshakes on both sides and suppresses false edges at line starts. Counts edge pixels per frame and sits between the pixel source (camera/frame buffer reader) and the VGA/frame writer.

Parameters:
W, 640, pixels per line (≥2)
H, 480, lines per frame (≥1)
CNT_W, 19, width of edge_count; must hold W*H
DEF_THRESH, 7, threshold loaded at reset (4 bits)

Ports:
clk  in  1  system clock; all registers on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a frame; honoured only in IDLE
cfg_we  in  1  threshold write strobe; honoured only in IDLE
cfg_thresh  in  4  threshold value written on cfg_we
pix_valid  in  1  source has a pixel
pix_in  in  24  source pixel; luma nibble = pix_in[23:20]
pix_ready  out  1  controller accepts pixel this cycle
out_valid  out  1  pix_out holds a result
pix_out  out  24  24'hFFFFFF = edge, 24'h000000 = no edge
out_ready  in  1  sink accepts pix_out
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse after the last result is consumed
edge_count  out  CNT_W  edges in the current/last frame; held until next start

Behaviour:
- Reset (rst=1 at a rising edge, any state, mid-frame included): state=IDLE; thresh=DEF_THRESH; col=0; row=0; prev=0; out_valid=0; pix_out=0; edge_count=0; frame_done=0. The partial frame is discarded.
- FSM states:
  - IDLE -> RUN on start. On that transition: edge_count=0, col=0, row=0.
  - RUN -> DRAIN on acceptance of pixel (col=W-1, row=H-1).
  - DRAIN -> DONE when out_valid=0, or out_valid&&out_ready.
  - DONE -> IDLE after one cycle. frame_done=1 only in DONE.
- Config: cfg_we in IDLE sets thresh<=cfg_thresh. Outside IDLE it is ignored. If cfg_we and start are asserted in the same IDLE cycle, the frame uses the new threshold.
- pix_ready = (state==RUN) && (!out_valid || out_ready). It is purely combinational from state and registers, with no dependency on pix_valid.
- Accept = pix_valid && pix_ready. On accept:
  - d = |pix_in[23:20] - prev|, computed unsigned in 4 bits, no wrap (larger minus smaller).
  - edge = (col!=0) && (d >= thresh).
  - pix_out <= edge ? 24'hFFFFFF : 24'h0; out_valid <= 1; prev <= pix_in[23:20].
  - edge_count increments if edge, saturating at all-ones.
  - col wraps W-1 -> 0 with row+1. row wraps only via the FSM exit.
- Latency: result registered one cycle after accept. Full throughput (one pixel per cycle) while out_ready=1.
- Output: when out_valid && out_ready with no accept in the same cycle, out_valid <= 0. pix_out holds its value while out_valid && !out_ready (back-pressure). When out_ready and an accept occur in the same cycle, the new result replaces the old one with out_valid staying 1.
- thresh=0: every non-column-0 pixel is an edge. thresh=15: edge only when d=15.
- start outside IDLE is ignored. pix_valid outside RUN is ignored (pix_ready=0).

Test Plan:
1. W=4,H=1,thresh=7, nibbles 0,7,7,15, out_ready=1 -> pix_out 0,FFFFFF,0,FFFFFF on consecutive cycles; edge_count=2; frame_done pulses 1 cycle after the last result.
2. W=4,H=2, row0 ends with nibble 15, row1 starts with 0 -> row1 col0 output 0 (line-start suppression); edge_count excludes it.
3. Back-pressure: out_ready=0 for 3 cycles mid-frame -> pix_ready=0 and pix_out stable for those cycles; no pixel lost or duplicated; totals match an ideal model.
4. cfg_we=1, cfg_thresh=2 in IDLE, then start; nibbles 5,3,4 -> outputs 0,FFFFFF,0. A cfg_we during RUN has no effect.
5. rst asserted on pixel 3 of 8 -> next cycle: out_valid=0, busy=0, edge_count=0, thresh=7. A new start runs a clean full frame.
6. Descending nibbles 12,4 vs ascending 4,12 with thresh=8 -> both give FFFFFF on the second pixel (absolute difference, no 4-bit wrap).
